// File: rtl/uart_rx_multi.sv
// UART receiver with configurable frame format, majority-vote bit sampling and an RX FIFO.
// The head FIFO entry (data plus its error flags) is presented combinationally on the outputs.
module uart_rx_multi #(
  parameter int FIFO_DEPTH = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_enable,
  input  logic [15:0]                   i_baud_div,
  input  logic [1:0]                    i_data_bits,
  input  logic [1:0]                    i_parity,
  input  logic                          i_stop2,
  input  logic                          i_rx,
  input  logic                          i_read,
  input  logic                          i_clear_err,
  output logic [7:0]                    o_data,
  output logic                          o_frame_err,
  output logic                          o_parity_err,
  output logic                          o_ready,
  output logic                          o_full,
  output logic [$clog2(FIFO_DEPTH):0]   o_count,
  output logic                          o_overrun
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(OVERSAMPLE);
  localparam logic [BW-1:0] SAMP0 = BW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] SAMP1 = BW'(OVERSAMPLE / 2);
  localparam logic [BW-1:0] SAMP2 = BW'(OVERSAMPLE / 2 + 1);
  localparam logic [BW-1:0] LAST  = BW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] ONE_T = BW'(1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

  state_t        state;
  logic          rx_meta, rx_sync, rx_prev;
  logic [15:0]   tick_cnt, baud_lat;
  logic [BW-1:0] bit_tick;
  logic [2:0]    bit_idx, nbits_m1;
  logic [1:0]    par_mode;
  logic          stop2_lat;
  logic          samp0, samp1;
  logic [7:0]    data_sr;
  logic          par_err, frm_err;

  logic          tick, maj_now, bit_end, maj, par_en, push;
  logic [9:0]    push_word;

  assign tick      = (tick_cnt == baud_lat);
  assign maj_now   = tick && (bit_tick == SAMP2);
  assign bit_end   = tick && (bit_tick == LAST);
  assign maj       = (samp0 & samp1) | (samp0 & rx_sync) | (samp1 & rx_sync);
  assign par_en    = (par_mode == 2'b01) || (par_mode == 2'b10);
  assign push      = i_enable && maj_now &&
                     (((state == STOP1) && !stop2_lat) || (state == STOP2));
  assign push_word = {par_err, frm_err | ~maj, data_sr};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Frame format and baud divisor are captured at the start edge so mid-frame changes are ignored.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      baud_lat  <= '0;
      bit_tick  <= '0;
      bit_idx   <= '0;
      nbits_m1  <= '0;
      par_mode  <= '0;
      stop2_lat <= 1'b0;
      samp0     <= 1'b1;
      samp1     <= 1'b1;
      data_sr   <= '0;
      par_err   <= 1'b0;
      frm_err   <= 1'b0;
    end else if (!i_enable) begin
      state <= IDLE;
    end else if (state == IDLE) begin
      if (rx_prev && !rx_sync) begin
        state     <= START;
        tick_cnt  <= '0;
        bit_tick  <= '0;
        bit_idx   <= '0;
        baud_lat  <= i_baud_div;
        nbits_m1  <= 3'd4 + {1'b0, i_data_bits};
        par_mode  <= i_parity;
        stop2_lat <= i_stop2;
        data_sr   <= '0;
        par_err   <= 1'b0;
        frm_err   <= 1'b0;
      end
    end else begin
      tick_cnt <= tick ? 16'd0 : tick_cnt + 16'd1;
      if (tick) begin
        bit_tick <= (bit_tick == LAST) ? '0 : bit_tick + ONE_T;
        if (bit_tick == SAMP0) samp0 <= rx_sync;
        if (bit_tick == SAMP1) samp1 <= rx_sync;
      end
      case (state)
        START: begin
          if (maj_now && maj) state <= IDLE;
          else if (bit_end)   state <= DATA;
        end
        DATA: begin
          if (maj_now) data_sr[bit_idx] <= maj;
          if (bit_end) begin
            if (bit_idx == nbits_m1) state <= par_en ? PARITY : STOP1;
            else                     bit_idx <= bit_idx + 3'd1;
          end
        end
        PARITY: begin
          if (maj_now) par_err <= (^data_sr) ^ maj ^ (par_mode == 2'b10);
          if (bit_end) state <= STOP1;
        end
        STOP1: begin
          if (maj_now) begin
            if (!maj) frm_err <= 1'b1;
            if (!stop2_lat) state <= IDLE;
          end else if (bit_end) begin
            state <= STOP2;
          end
        end
        STOP2: begin
          if (maj_now) begin
            if (!maj) frm_err <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          overrun;
  logic          pop, full, wr_en, drop;
  logic [9:0]    head;

  assign full  = (count == CW'(FIFO_DEPTH));
  assign pop   = i_read && (count != '0);
  // A push into a full FIFO is only accepted when a pop frees the head slot in the same cycle.
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      overrun <= drop | (overrun & ~i_clear_err);
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_ptr] <= push_word;
  end

  assign head         = mem[rd_ptr];
  assign o_ready      = (count != '0);
  assign o_full       = full;
  assign o_count      = count;
  assign o_overrun    = overrun;
  assign o_data       = o_ready ? head[7:0] : 8'd0;
  assign o_frame_err  = o_ready ? head[8]   : 1'b0;
  assign o_parity_err = o_ready ? head[9]   : 1'b0;

endmodule

// File: doc/uart_rx_multi.md
UART_RX_MULTI -- requirements
Module: uart_rx_multi

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, RX FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter OVERSAMPLE, default 16, ticks per bit (even, >=8).
REQ-003 SHALL have port i_clk  input  1  sole clock; all state updates on posedge.
REQ-004 SHALL have port i_reset  input  1  synchronous reset, active-high.
REQ-005 SHALL have port i_enable  input  1  receiver enable.
REQ-006 SHALL have port i_baud_div  input  16  oversample tick every i_baud_div+1 clocks.
REQ-007 SHALL have port i_data_bits  input  2  00=5, 01=6, 10=7, 11=8 data bits.
REQ-008 SHALL have port i_parity  input  2  00=none, 01=even, 10=odd, 11=none.
REQ-009 SHALL have port i_stop2  input  1  1 = two stop bits checked.
REQ-010 SHALL have port i_rx  input  1  asynchronous serial line, idle high.
REQ-011 SHALL have port i_read  input  1  single-cycle pop strobe.
REQ-012 SHALL have port i_clear_err  input  1  clears sticky overrun.
REQ-013 SHALL have port o_data  output  8  head entry data, zero-extended.
REQ-014 SHALL have port o_frame_err  output  1  head entry framing error.
REQ-015 SHALL have port o_parity_err  output  1  head entry parity error.
REQ-016 SHALL have port o_ready  output  1  FIFO not empty.
REQ-017 SHALL have port o_full  output  1  FIFO full.
REQ-018 SHALL have port o_count  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
REQ-019 SHALL have port o_overrun  output  1  sticky: frame dropped because FIFO was full.

Function
REQ-020 i_rx SHALL pass a 2-flop synchroniser; all sampling uses the synchronised value.
REQ-021 Tick counter SHALL count 0..i_baud_div and emit a one-clock tick on reaching i_baud_div; i_baud_div=0 gives a tick every clock.
REQ-022 FSM states SHALL be IDLE, START, DATA, PARITY, STOP1, STOP2.
REQ-023 IDLE->START on a synchronised 1->0 edge; tick counter and bit-tick counter restart at 0; i_data_bits, i_parity, i_stop2 latched.
REQ-024 Each bit SHALL span OVERSAMPLE ticks; value = 2-of-3 majority of samples at ticks OVERSAMPLE/2-1, /2, /2+1.
REQ-025 START majority 1 SHALL be a false start: return to IDLE, no push.
REQ-026 DATA SHALL shift in latched-count bits LSB first; then PARITY if parity enabled, else STOP1.
REQ-027 Parity error SHALL be set if XOR(data bits, parity bit) is 1 for even, or 0 for odd.
REQ-028 Framing error SHALL be set if any checked stop-bit majority is 0.
REQ-029 On the mid-bit majority sample of the final stop bit (STOP1, or STOP2 if latched i_stop2), the FSM SHALL push {parity_err, frame_err, data} and return to IDLE in the same clock.
REQ-030 Push SHALL assert o_ready on the following clock; o_data/o_*_err SHALL show the head entry combinationally from FIFO storage.
REQ-031 i_read with o_ready=1 SHALL pop one entry; i_read while empty SHALL be ignored.
REQ-032 Push while full with no same-cycle pop SHALL drop the frame and set o_overrun; push and pop in the same cycle while full SHALL succeed, count unchanged, no overrun.
REQ-033 o_overrun SHALL clear on i_clear_err unless a dropping push occurs the same cycle, in which case it stays 1.
REQ-034 Pointers SHALL wrap modulo FIFO_DEPTH; o_count SHALL range 0..FIFO_DEPTH.
REQ-035 i_enable=0 SHALL force IDLE and discard any partial frame; FIFO contents, pops and o_overrun unaffected.
REQ-036 Configuration input changes mid-frame SHALL NOT affect the frame in progress.

Reset
REQ-037 i_reset=1 at a posedge SHALL set: FSM IDLE, all counters 0, synchroniser flops 1, FIFO empty, o_ready=0, o_full=0, o_count=0, o_overrun=0, o_data=0, o_frame_err=0, o_parity_err=0.
REQ-038 Reset mid-frame SHALL discard the frame; no push after reset release until a new start edge.

Verification
REQ-039 baud_div=0, 8N1, send 0xA5 -> o_ready rises 150..160 clocks after the falling edge; o_data=0xA5, both err=0; i_read -> o_ready=0.
REQ-040 7 data bits, even parity, send 0x41 with parity bit 1 -> o_data=0x41, o_parity_err=1; same with parity 0 -> o_parity_err=0.
REQ-041 8N1 byte 0x3C with stop bit held 0 -> o_frame_err=1, o_data=0x3C; 8N2 with second stop 0 -> o_frame_err=1.
REQ-042 Low pulse of 4 ticks (OVERSAMPLE=16) -> no push, FSM back in IDLE, o_count=0.
REQ-043 FIFO_DEPTH=8: send 9 bytes without read -> o_full=1, o_count=8, o_overrun=1, entries 1..8 intact; i_clear_err -> o_overrun=0; push coincident with pop when full -> o_count=8, o_overrun stays 0.
REQ-044 i_enable=0 and i_reset mid-frame -> no push; the next full frame is received correctly.
